// File: rtl/mam_mem_arbiter.sv
// rtl/mam_mem_arbiter.sv - round-robin arbiter sharing one MAM-style memory port among N_REQ requesters
module mam_mem_arbiter #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    localparam int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [N_REQ-1:0]              in_req_valid,
    output logic [N_REQ-1:0]              in_req_ready,
    input  logic [N_REQ-1:0]              in_req_rw,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   in_req_addr,
    input  logic [N_REQ-1:0]              in_req_burst,
    input  logic [N_REQ*14-1:0]           in_req_beats,

    input  logic [N_REQ-1:0]              in_write_valid,
    output logic [N_REQ-1:0]              in_write_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0]   in_write_data,
    input  logic [N_REQ*DATA_WIDTH/8-1:0] in_write_strb,

    output logic [N_REQ-1:0]              in_read_valid,
    output logic [DATA_WIDTH-1:0]         in_read_data,
    input  logic [N_REQ-1:0]              in_read_ready,

    output logic                          req_valid,
    output logic                          req_rw,
    output logic                          req_burst,
    output logic [ADDR_WIDTH-1:0]         req_addr,
    output logic [13:0]                   req_beats,
    input  logic                          req_ready,

    output logic                          write_valid,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [DATA_WIDTH/8-1:0]       write_strb,
    input  logic                          write_ready,

    input  logic                          read_valid,
    input  logic [DATA_WIDTH-1:0]         read_data,
    output logic                          read_ready,

    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_grant_id;
    logic [GW-1:0] w_grant_nxt;
    logic [GW-1:0] r_rr_last;
    logic [GW-1:0] w_rr_last_nxt;
    logic [13:0]   r_beat_cnt;
    logic [13:0]   w_beat_cnt_nxt;

    logic          w_arb_found;
    logic [GW-1:0] w_arb_id;
    logic [GW-1:0] w_arb_cand;

    logic          w_req_hs;
    logic          w_write_hs;
    logic          w_read_hs;
    logic [13:0]   w_req_len;

    // Search starts just after the last completed grant, wrapping around.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_id    = r_rr_last;
        w_arb_cand  = r_rr_last;
        for (int i = 1; i <= N_REQ; i++) begin
            w_arb_cand = GW'((int'(r_rr_last) + i) % N_REQ);
            if (!w_arb_found && in_req_valid[w_arb_cand]) begin
                w_arb_found = 1'b1;
                w_arb_id    = w_arb_cand;
            end
        end
    end

    // Memory-side fields always follow the granted requester so they stay driven.
    assign req_rw       = in_req_rw[r_grant_id];
    assign req_burst    = in_req_burst[r_grant_id];
    assign req_addr     = in_req_addr[r_grant_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_beats    = in_req_beats[r_grant_id*14 +: 14];
    assign write_data   = in_write_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign write_strb   = in_write_strb[r_grant_id*(DATA_WIDTH/8) +: (DATA_WIDTH/8)];
    assign in_read_data = read_data;

    assign grant_id = r_grant_id;
    assign busy     = (r_state != ST_IDLE);

    always_comb begin
        in_req_ready   = '0;
        in_write_ready = '0;
        in_read_valid  = '0;
        req_valid      = 1'b0;
        write_valid    = 1'b0;
        read_ready     = 1'b0;
        case (r_state)
            ST_REQ: begin
                req_valid                = in_req_valid[r_grant_id];
                in_req_ready[r_grant_id] = req_ready;
            end
            ST_WRITE: begin
                write_valid                = in_write_valid[r_grant_id];
                in_write_ready[r_grant_id] = write_ready;
            end
            ST_READ: begin
                in_read_valid[r_grant_id] = read_valid;
                read_ready                = in_read_ready[r_grant_id];
            end
            default: begin
            end
        endcase
    end

    assign w_req_hs   = req_valid && req_ready;
    assign w_write_hs = write_valid && write_ready;
    assign w_read_hs  = read_valid && read_ready;
    assign w_req_len  = req_burst ? req_beats : 14'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant_id;
        w_rr_last_nxt  = r_rr_last;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_grant_nxt = w_arb_id;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_req_hs) begin
                    w_beat_cnt_nxt = w_req_len;
                    if (w_req_len == 14'd0) begin
                        // Zero-length burst has no data phase; still counts as a served grant.
                        w_state_nxt   = ST_IDLE;
                        w_rr_last_nxt = r_grant_id;
                    end else if (req_rw) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_WRITE, ST_READ: begin
                if ((r_state == ST_WRITE && w_write_hs) ||
                    (r_state == ST_READ && w_read_hs)) begin
                    // <= 1 rather than == 1 so a corrupted count can never wrap through zero.
                    if (r_beat_cnt <= 14'd1) begin
                        w_state_nxt    = ST_IDLE;
                        w_rr_last_nxt  = r_grant_id;
                        w_beat_cnt_nxt = 14'd0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt - 14'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_rr_last  <= GW'(N_REQ - 1);
            r_beat_cnt <= 14'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_nxt;
            r_rr_last  <= w_rr_last_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule
